// File: rtl/shift_reg_seq_pkg.sv
// Shared types and constants for the counted shift register.
// Rotate support is enabled with SHIFT_REG_SEQ_ROTATE_EN.
package shift_reg_seq_pkg;

    typedef enum logic [1:0] {
        MODE_LOGIC = 2'b00,
        MODE_ARITH = 2'b01,
        MODE_ROT   = 2'b10,
        MODE_RSVD  = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_reg_step.sv
// One-step shifter: logical, arithmetic or rotate, left or right.
// Rotate exists only with SHIFT_REG_SEQ_ROTATE_EN; otherwise it fills like logical.
module shift_reg_step
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  shift_mode_t      mode_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    logic fill;

    always_comb begin
        fill = fill_i;
        case (mode_i)
            MODE_ARITH: fill = (dir_i == DIR_LEFT) ? 1'b0 : data_i[WIDTH-1];
`ifdef SHIFT_REG_SEQ_ROTATE_EN
            MODE_ROT:   fill = (dir_i == DIR_LEFT) ? data_i[WIDTH-1] : data_i[0];
`endif
            default:    fill = fill_i;
        endcase
        if (dir_i == DIR_LEFT) begin
            data_o = {data_i[WIDTH-2:0], fill};
        end else begin
            data_o = {fill, data_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_reg_seq.sv
// WIDTH-bit load/shift register with a counted multi-cycle shift sequencer.
// Define SHIFT_REG_SEQ_ROTATE_EN to enable rotate mode in shift_reg_step.
module shift_reg_seq
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Shift_En,
    input  logic             Shift_In,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic             Dir,
    input  logic [1:0]       Mode,
    output logic             Busy,
    output logic             Done,
    output logic             Shift_Out,
    output logic [WIDTH-1:0] Data_Out
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    shift_mode_t      mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic             step_dir;
    shift_mode_t      step_mode;
    logic [WIDTH-1:0] step_out;
    logic [CNT_W-1:0] count_clamped;

    assign count_clamped = (Count > CNT_MAX) ? CNT_MAX : Count;

    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (data_q),
        .dir_i  (step_dir),
        .mode_i (step_mode),
        .fill_i (Shift_In),
        .data_o (step_out)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        rem_d     = rem_q;
        step_dir  = dir_q;
        step_mode = mode_q;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    data_d = D;
                end else if (Start) begin
                    dir_d   = Dir;
                    mode_d  = shift_mode_t'(Mode);
                    rem_d   = count_clamped;
                    state_d = (count_clamped == '0) ? DONE : SHIFT;
                end else if (Shift_En) begin
                    // Legacy step is always logical right and retargets Shift_Out.
                    step_dir  = DIR_RIGHT;
                    step_mode = MODE_LOGIC;
                    data_d    = step_out;
                    dir_d     = DIR_RIGHT;
                end
            end
            SHIFT: begin
                data_d = step_out;
                rem_d  = rem_q - CNT_ONE;
                if (rem_q <= CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            dir_q   <= DIR_RIGHT;
            mode_q  <= MODE_LOGIC;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);
    assign Shift_Out = (dir_q == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];
    assign Data_Out  = data_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed self-checking bench for shift_reg_seq (WIDTH = 8).
// Honours SHIFT_REG_SEQ_ROTATE_EN for the rotate expectation.
module tb_shift_reg_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Load;
    logic [7:0] D;
    logic       Shift_En;
    logic       Shift_In;
    logic       Start;
    logic [3:0] Count;
    logic       Dir;
    logic [1:0] Mode;
    logic       Busy;
    logic       Done;
    logic       Shift_Out;
    logic [7:0] Data_Out;

    int checks = 0;
    int errors = 0;

    shift_reg_seq #(
        .WIDTH (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (Load),
        .D         (D),
        .Shift_En  (Shift_En),
        .Shift_In  (Shift_In),
        .Start     (Start),
        .Count     (Count),
        .Dir       (Dir),
        .Mode      (Mode),
        .Busy      (Busy),
        .Done      (Done),
        .Shift_Out (Shift_Out),
        .Data_Out  (Data_Out)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] val);
        Load = 1'b1;
        D    = val;
        tick();
        Load = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] n, input logic dr, input logic [1:0] md);
        Start = 1'b1;
        Count = n;
        Dir   = dr;
        Mode  = md;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        do_load(8'hA7);
        do_start(4'd5, 1'b1, 2'b01);
        tick();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if (Data_Out !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0 || Shift_Out !== 1'b0) begin
            errors++;
            $display("FAIL reset: data=%h busy=%b done=%b so=%b, want 00 0 0 0",
                     Data_Out, Busy, Done, Shift_Out);
        end
    endtask

    task automatic test_logical_right();
        logic [7:0] exp [3];
        int busy_n;
        exp[0] = 8'h5A;
        exp[1] = 8'h2D;
        exp[2] = 8'h16;
        Shift_In = 1'b0;
        do_load(8'hB4);
        checks++;
        if (Data_Out !== 8'hB4) begin
            errors++;
            $display("FAIL load_b4: data=%h want b4", Data_Out);
        end
        do_start(4'd3, 1'b0, 2'b00);
        busy_n = Busy ? 1 : 0;
        checks++;
        if (Data_Out !== 8'hB4 || Busy !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL lr_start: data=%h busy=%b done=%b want b4 1 0", Data_Out, Busy, Done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Busy) busy_n++;
            checks++;
            if (Data_Out !== exp[i] || Done !== (i == 2)) begin
                errors++;
                $display("FAIL lr_step%0d: data=%h done=%b want %h %b",
                         i, Data_Out, Done, exp[i], (i == 2));
            end
        end
        tick();
        if (Busy) busy_n++;
        checks++;
        if (busy_n != 4 || Done !== 1'b0 || Data_Out !== 8'h16) begin
            errors++;
            $display("FAIL lr_end: busy_cycles=%0d done=%b data=%h want 4 0 16",
                     busy_n, Done, Data_Out);
        end
    endtask

    task automatic test_arith_right();
        do_load(8'h90);
        do_start(4'd2, 1'b0, 2'b01);
        tick();
        checks++;
        if (Data_Out !== 8'hC8) begin
            errors++;
            $display("FAIL ar_step0: data=%h want c8", Data_Out);
        end
        tick();
        checks++;
        if (Data_Out !== 8'hE4 || Done !== 1'b1 || Shift_Out !== 1'b0) begin
            errors++;
            $display("FAIL ar_done: data=%h done=%b so=%b want e4 1 0", Data_Out, Done, Shift_Out);
        end
        tick();
    endtask

    task automatic test_rotate_left();
        logic [7:0] exp;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
        exp = 8'h03;
`else
        exp = 8'h02;
`endif
        Shift_In = 1'b0;
        do_load(8'h81);
        do_start(4'd1, 1'b1, 2'b10);
        checks++;
        if (Shift_Out !== 1'b1) begin
            errors++;
            $display("FAIL rot_so: so=%b want 1", Shift_Out);
        end
        tick();
        checks++;
        if (Data_Out !== exp || Done !== 1'b1) begin
            errors++;
            $display("FAIL rot_left: data=%h done=%b want %h 1", Data_Out, Done, exp);
        end
        tick();
    endtask

    task automatic test_count_zero_clamp();
        int busy_n;
        int done_n;
        Shift_In = 1'b0;
        do_load(8'h3C);
        do_start(4'd0, 1'b0, 2'b00);
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b1 || Data_Out !== 8'h3C) begin
            errors++;
            $display("FAIL cnt0: busy=%b done=%b data=%h want 1 1 3c", Busy, Done, Data_Out);
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Data_Out !== 8'h3C) begin
            errors++;
            $display("FAIL cnt0_end: busy=%b done=%b data=%h want 0 0 3c", Busy, Done, Data_Out);
        end
        do_start(4'd9, 1'b0, 2'b00);
        busy_n = Busy ? 1 : 0;
        done_n = 0;
        Load     = 1'b1;
        D        = 8'hFF;
        Start    = 1'b1;
        Count    = 4'd1;
        Dir      = 1'b1;
        Shift_En = 1'b1;
        for (int i = 0; i < 20 && Busy; i++) begin
            tick();
            if (Busy) busy_n++;
            if (Done) done_n++;
        end
        Load     = 1'b0;
        Start    = 1'b0;
        Shift_En = 1'b0;
        checks++;
        if (busy_n != 9 || done_n != 1 || Data_Out !== 8'h00 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL clamp: busy_cycles=%0d dones=%0d data=%h busy=%b want 9 1 00 0",
                     busy_n, done_n, Data_Out, Busy);
        end
    endtask

    task automatic test_back_to_back();
        Shift_In = 1'b0;
        do_load(8'h01);
        do_start(4'd1, 1'b1, 2'b00);
        tick();
        Start = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b0 || Data_Out !== 8'h02) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b data=%h want 0 02", Busy, Data_Out);
        end
        tick();
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b want 1", Busy);
        end
        tick();
        checks++;
        if (Data_Out !== 8'h04 || Done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_shift: data=%h done=%b want 04 1", Data_Out, Done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        Shift_In = 1'b0;
        do_load(8'hFF);
        do_start(4'd5, 1'b1, 2'b00);
        tick();
        tick();
        checks++;
        if (Data_Out !== 8'hFC || Busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: data=%h busy=%b want fc 1", Data_Out, Busy);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (Data_Out !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: data=%h busy=%b done=%b want 00 0 0", Data_Out, Busy, Done);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_nodone: done=%b busy=%b want 0 0", Done, Busy);
        end
        Shift_In = 1'b1;
        Shift_En = 1'b1;
        tick();
        Shift_En = 1'b0;
        checks++;
        if (Data_Out !== 8'h80 || Shift_Out !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL shift_en: data=%h so=%b busy=%b done=%b want 80 0 0 0",
                     Data_Out, Shift_Out, Busy, Done);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        Load     = 1'b0;
        D        = 8'h00;
        Shift_En = 1'b0;
        Shift_In = 1'b0;
        Start    = 1'b0;
        Count    = 4'd0;
        Dir      = 1'b0;
        Mode     = 2'b00;
        tick();
        Reset = 1'b0;
        test_reset();
        test_logical_right();
        test_arith_right();
        test_rotate_left();
        test_count_zero_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parametrised successor of the team's 8-bit load/shift register: a WIDTH-bit register with parallel load, legacy single-step right shift, and a multi-cycle shift sequencer. The sequencer applies a programmed number of one-bit shifts (left/right; logical, arithmetic or rotate), with a Busy/Done handshake. It sits under the add-shift multiplier control path and any datapath needing counted shifts without an external counter.

## Interface
- WIDTH, 8: register width in bits, ≥2
- CNT_W, $clog2(WIDTH+1): width of Count
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Load  in  1  parallel load of D (idle only)
- D  in  WIDTH  parallel load data
- Shift_En  in  1  legacy single-step logical right shift, Shift_In into MSB (idle only)
- Shift_In  in  1  serial fill bit for logical shifts
- Start  in  1  begin counted shift sequence (idle only)
- Count  in  CNT_W  number of shifts; values >WIDTH clamp to WIDTH
- Dir  in  1  0 = right, 1 = left; latched at Start
- Mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (= logical); latched at Start
- Busy  out  1  high while state ≠ IDLE
- Done  out  1  one-cycle completion pulse
- Shift_Out  out  1  bit next to leave: Data_Out[0] if latched dir = right, Data_Out[WIDTH-1] if left
- Data_Out  out  WIDTH  register contents

## Operation
- States: IDLE, SHIFT, DONE.
- Idle priority on each edge: Reset > Load > Start > Shift_En; only the highest asserted acts.
- Start latches Dir, Mode, and remaining = min(Count, WIDTH). Next state is SHIFT, or DONE if remaining = 0. Data is not shifted on the Start edge.
- SHIFT: each edge performs one step and decrements remaining. After the step that takes remaining from 1 to 0, the next state is DONE.
- DONE: Done = 1 for exactly one cycle, then IDLE unconditionally.
- Step rules:
  - Logical right: {Shift_In, D[W-1:1]}. Logical left: {D[W-2:0], Shift_In}.
  - Arithmetic right: {D[W-1], D[W-1:1]}. Arithmetic left: {D[W-2:0], 0}.
  - Rotate right: {D[0], D[W-1:1]}. Rotate left: {D[W-2:0], D[W-1]}.
- Shift_In is sampled live on every SHIFT edge.
- While Busy: Load, Start and Shift_En are ignored; D, Count, Dir and Mode are don't-care.
- Shift_En step uses latched dir = right for Shift_Out selection; it does not touch Busy/Done.
- Reset at any time, including mid-sequence: next edge Data_Out = 0, state IDLE, latched dir = right, latched mode = logical, remaining = 0.
- Reset values: Data_Out 0, Busy 0, Done 0, Shift_Out 0.

## Timing
- Load and Shift_En: result on Data_Out one cycle after the sampling edge.
- Start at edge E with Count = N (1..WIDTH): shifts on edges E+1..E+N; Done high in the cycle after edge E+N; Busy high from after E until after E+N+1.
- Count = 0: Done high in the cycle after E; Busy high for that one cycle; Data_Out unchanged.
- Back-to-back Start is accepted in the first IDLE cycle after DONE. Minimum sequence period is N+2 cycles.
- Busy, Done and Shift_Out are decoded from registered state only; there are no combinational input-to-output paths except through Data_Out.

## Configuration
- SHIFT_REG_SEQ_ROTATE_EN defined: Mode 10 performs rotate as specified.
- Undefined: Mode 10 behaves as logical (Shift_In fill). Rotate logic is absent from the netlist.

## Structure
- Package shift_reg_seq_pkg holds:
  - typedef enum logic [1:0] shift_mode_t: MODE_LOGIC, MODE_ARITH, MODE_ROT, MODE_RSVD
  - typedef enum logic [1:0] seq_state_t: IDLE, SHIFT, DONE
  - constants DIR_RIGHT = 0, DIR_LEFT = 1
- Sub-module shift_reg_step: combinational, parametrised on WIDTH. Inputs are data, dir, mode and fill bit; output is the one-step result. It carries the rotate `ifdef`, and the top module instantiates it once.

## Test plan
- Reset asserted for 2 cycles from random state -> Data_Out 0x00, Busy 0, Done 0, Shift_Out 0.
- Load D=0xB4; Start Count=3, Dir=0, Mode=00, Shift_In=0 -> Data_Out 0x5A, 0x2D, 0x16 on successive edges; Done one cycle; Busy high 4 cycles.
- Load 0x90; Start Count=2, Dir=0, Mode=01 -> Data_Out 0xE4; Shift_Out = 0 at Done.
- Load 0x81; Start Count=1, Dir=1, Mode=10, Shift_In=0 -> 0x03 with SHIFT_REG_SEQ_ROTATE_EN, 0x02 without.
- Load 0x3C; Start Count=0 -> Done the next cycle, Data_Out stays 0x3C. Then Start Count=9 (CNT_W=4) -> clamped to 8 shifts, Data_Out 0x00 with Shift_In=0. Load/Start/Shift_En pulses applied while Busy -> no effect.
- Load 0xFF; Start Count=5, Dir=1; Reset asserted after the 2nd shift -> next edge Data_Out 0x00, Busy 0, no Done pulse; a subsequent Shift_En with Shift_In=1 -> 0x80.
